guess_judge: RTL and testbench

//  Game-control stage downstream of the target generator in the guess-number design.
//  - Requests a new 3-digit target: three distinct BCD digits, each 0..DIGIT_MAX, packed as [11:8][7:4][3:0].
//  - Latches the target, then accepts player guesses.
//  - Scores each guess as hits (right digit, right place) and blows (right digit, wrong place).
//  - Counts attempts and flags win or lose.

---
 rtl/gn_pkg.sv | 25 ++
 rtl/guess_validate.sv | 28 ++
 rtl/guess_judge.sv | 137 +++++++++++++
 tb/tb_guess_judge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gn_pkg.sv
// Shared types and helpers for the guess-number game: code geometry, FSM states,
// and digit extraction from a packed BCD code.
package gn_pkg;

  localparam int NDIG    = 3;
  localparam int DIGIT_W = 4;
  localparam int CODE_W  = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    READY,
    CHECK,
    WIN,
    LOSE
  } gn_state_t;

  // Digit 0 is the least significant nibble.
  function automatic logic [DIGIT_W-1:0] digit(input logic [CODE_W-1:0] code,
                                               input logic [1:0]        i);
    return DIGIT_W'(code >> (DIGIT_W * i));
  endfunction

endpackage

// File: rtl/guess_validate.sv
// Combinational legality check of a packed code: every digit in 0..DIGIT_MAX and
// no digit repeated. Also usable to self-check generator targets in simulation.
import gn_pkg::*;

module guess_validate #(
  parameter int DIGIT_MAX = 5
) (
  input  logic [CODE_W-1:0] code,
  output logic              valid
);

  logic [NDIG-1:0] dig_ok;
  logic            distinct;

  for (genvar i = 0; i < NDIG; i++) begin : g_rng
    assign dig_ok[i] = digit(code, 2'(i)) <= DIGIT_W'(DIGIT_MAX);
  end

  always_comb begin
    distinct = 1'b1;
    for (int i = 0; i < NDIG; i++)
      for (int j = i + 1; j < NDIG; j++)
        if (digit(code, 2'(i)) == digit(code, 2'(j))) distinct = 1'b0;
  end

  assign valid = (&dig_ok) && distinct;

endmodule

// File: rtl/guess_judge.sv
// Game control: requests a target, validates and scores guesses one digit per
// cycle, tracks attempts and reports win/lose. All outputs are registered.
import gn_pkg::*;

module guess_judge #(
  parameter int MAX_TRIES = 8,
  parameter int DIGIT_MAX = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] target,
  input  logic [CODE_W-1:0] guess,
  input  logic              submit,
  output logic              gen_req,
  output logic [1:0]        hits,
  output logic [1:0]        blows,
  output logic              result_valid,
  output logic              guess_invalid,
  output logic [3:0]        tries,
  output logic              win,
  output logic              lose,
  output logic              busy
);

  gn_state_t state_q, state_n;

  logic [CODE_W-1:0]  tgt_q, gss_q;
  logic [1:0]         idx_q;
  logic [1:0]         hit_acc, blow_acc;
  logic [1:0]         hit_sum, blow_sum;
  logic [DIGIT_W-1:0] g_dig;
  logic               is_hit, is_blow, last;
  logic               guess_ok;
  logic [4:0]         tries_nx;

  guess_validate #(.DIGIT_MAX(DIGIT_MAX)) u_val (
    .code  (guess),
    .valid (guess_ok)
  );

  // Per-digit scoring of the latched guess against the latched target.
  always_comb begin
    g_dig   = digit(gss_q, idx_q);
    is_hit  = g_dig == digit(tgt_q, idx_q);
    is_blow = 1'b0;
    for (int j = 0; j < NDIG; j++)
      if (2'(j) != idx_q && g_dig == digit(tgt_q, 2'(j)) && !is_hit) is_blow = 1'b1;
    hit_sum  = hit_acc + {1'b0, is_hit};
    blow_sum = blow_acc + {1'b0, is_blow};
    last     = idx_q == 2'(NDIG - 1);
    tries_nx = {1'b0, tries} + 5'd1;
  end

  always_comb begin
    state_n = state_q;
    if (start) state_n = LOAD;
    else begin
      case (state_q)
        LOAD:  state_n = WAIT;
        WAIT:  state_n = READY;
        READY: if (submit && guess_ok) state_n = CHECK;
        CHECK: if (last) begin
          if (hit_sum == 2'd3)                 state_n = WIN;
          else if (tries_nx == 5'(MAX_TRIES))  state_n = LOSE;
          else                                 state_n = READY;
        end
        default: state_n = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q         <= '0;
      gss_q         <= '0;
      idx_q         <= '0;
      hit_acc       <= '0;
      blow_acc      <= '0;
      gen_req       <= 1'b0;
      hits          <= '0;
      blows         <= '0;
      result_valid  <= 1'b0;
      guess_invalid <= 1'b0;
      tries         <= '0;
      win           <= 1'b0;
      lose          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      gen_req       <= state_n == LOAD;
      busy          <= state_n inside {LOAD, WAIT, CHECK};
      win           <= state_n == WIN;
      lose          <= state_n == LOSE;
      result_valid  <= 1'b0;
      guess_invalid <= 1'b0;
      if (start) begin
        // Restart aborts any scoring in flight; nothing from the old game survives.
        tries <= '0;
        hits  <= '0;
        blows <= '0;
      end else begin
        case (state_q)
          WAIT: tgt_q <= target;
          READY: if (submit) begin
            if (guess_ok) begin
              gss_q    <= guess;
              idx_q    <= '0;
              hit_acc  <= '0;
              blow_acc <= '0;
            end else begin
              guess_invalid <= 1'b1;
            end
          end
          CHECK: begin
            if (last) begin
              hits         <= hit_sum;
              blows        <= blow_sum;
              tries        <= tries_nx[3:0];
              result_valid <= 1'b1;
            end else begin
              idx_q    <= idx_q + 2'd1;
              hit_acc  <= hit_sum;
              blow_acc <= blow_sum;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_judge.sv
// Directed bench for guess_judge: a vector table for one full game plus short
// hand-written sequences for restart, exhaustion, ignored submits and reset.
module tb_guess_judge;

  logic        clk = 1'b0;
  logic        rst, start, submit;
  logic [11:0] target, guess, tb_target;
  logic        gen_req, result_valid, guess_invalid, win, lose, busy;
  logic [1:0]  hits, blows;
  logic [3:0]  tries;

  int nvec = 0;
  int nerr = 0;

  guess_judge #(.MAX_TRIES(8), .DIGIT_MAX(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .target        (target),
    .guess         (guess),
    .submit        (submit),
    .gen_req       (gen_req),
    .hits          (hits),
    .blows         (blows),
    .result_valid  (result_valid),
    .guess_invalid (guess_invalid),
    .tries         (tries),
    .win           (win),
    .lose          (lose),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Generator model: target is meaningful only in the cycle after gen_req.
  always @(posedge clk) target <= gen_req ? tb_target : 12'hfff;

  // kind: 0 = scored, 1 = rejected, 2 = ignored
  typedef struct {
    logic [11:0] g;
    int          kind;
    logic [1:0]  h, b;
    logic [3:0]  t;
    logic        w, l;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic new_game(input logic [11:0] t);
    tb_target = t;
    pulse_start();
    tick();
    tick();
  endtask

  // Submit and wait (bounded) for either pulse; returns cycles waited and what came.
  task automatic do_submit(input logic [11:0] g, output int lat, output int kind);
    guess  = g;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    lat  = 0;
    kind = 2;
    while (lat < 6) begin
      if (result_valid) begin kind = 0; break; end
      if (guess_invalid) begin kind = 1; break; end
      tick();
      lat++;
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    int lat, kind;
    do_submit(v.g, lat, kind);
    chk({tag, " kind"}, kind, v.kind);
    chk({tag, " latency"}, lat, (v.kind == 0) ? 3 : (v.kind == 1) ? 0 : 6);
    chk({tag, " hits"}, hits, v.h);
    chk({tag, " blows"}, blows, v.b);
    chk({tag, " tries"}, tries, v.t);
    chk({tag, " win"}, win, v.w);
    chk({tag, " lose"}, lose, v.l);
  endtask

  initial begin
    int   rv_cnt, inv_cnt, gr_cnt;
    vec_t v;

    tbl[0] = '{12'h456, 1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{12'h112, 1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
    tbl[2] = '{12'h132, 0, 2'd1, 2'd2, 4'd1, 1'b0, 1'b0};
    tbl[3] = '{12'h045, 0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0};
    tbl[4] = '{12'h321, 0, 2'd1, 2'd2, 4'd3, 1'b0, 1'b0};
    tbl[5] = '{12'h123, 0, 2'd3, 2'd0, 4'd4, 1'b1, 1'b0};
    tbl[6] = '{12'h105, 2, 2'd3, 2'd0, 4'd4, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; submit = 1'b0; guess = '0; tb_target = 12'h123;
    repeat (3) tick();
    chk("reset outputs",
        {gen_req, hits, blows, result_valid, guess_invalid, tries, win, lose, busy}, 0);
    rst = 1'b0;
    repeat (6) tick();

    // Start/load timing: gen_req one cycle, busy two cycles, then READY.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load gen_req", gen_req, 1);
    chk("load busy", busy, 1);
    tick();
    chk("wait gen_req", gen_req, 0);
    chk("wait busy", busy, 1);
    tick();
    chk("ready busy", busy, 0);

    for (int i = 0; i < 7; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Submit during CHECK is ignored; only the first guess is scored.
    new_game(12'h123);
    guess = 12'h045; submit = 1'b1;
    tick();
    guess = 12'h105;
    tick();
    submit = 1'b0;
    rv_cnt = 0; inv_cnt = 0;
    repeat (8) begin
      if (result_valid) rv_cnt++;
      if (guess_invalid) inv_cnt++;
      tick();
    end
    chk("check-submit results", rv_cnt, 1);
    chk("check-submit rejects", inv_cnt, 0);
    chk("check-submit tries", tries, 1);

    // Start mid-CHECK aborts scoring.
    guess = 12'h132; submit = 1'b1;
    tick();
    submit = 1'b0;
    pulse_start();
    chk("abort gen_req", gen_req, 1);
    chk("abort tries", tries, 0);
    chk("abort hits", hits, 0);
    rv_cnt = 0;
    repeat (5) begin
      if (result_valid) rv_cnt++;
      tick();
    end
    chk("abort no result", rv_cnt, 0);

    // Exhaustion: eight misses lose, ninth submit ignored.
    new_game(12'h123);
    for (int k = 1; k <= 8; k++) begin
      v = '{12'h045, 0, 2'd0, 2'd0, 4'(k), 1'b0, (k == 8)};
      apply($sformatf("miss%0d", k), v);
    end
    v = '{12'h045, 2, 2'd0, 2'd0, 4'd8, 1'b0, 1'b1};
    apply("miss9", v);

    // Win on the final allowed try.
    new_game(12'h123);
    for (int k = 1; k <= 7; k++) begin
      v = '{12'h045, 0, 2'd0, 2'd0, 4'(k), 1'b0, 1'b0};
      apply($sformatf("pre%0d", k), v);
    end
    v = '{12'h123, 0, 2'd3, 2'd0, 4'd8, 1'b1, 1'b0};
    apply("lastwin", v);

    // start and submit on the same edge: start wins.
    new_game(12'h123);
    guess = 12'h132; submit = 1'b1; start = 1'b1;
    tick();
    submit = 1'b0; start = 1'b0;
    chk("both gen_req", gen_req, 1);
    rv_cnt = 0; inv_cnt = 0; gr_cnt = 0;
    repeat (6) begin
      if (result_valid) rv_cnt++;
      if (guess_invalid) inv_cnt++;
      if (gen_req) gr_cnt++;
      tick();
    end
    chk("both no result", rv_cnt + inv_cnt, 0);
    chk("both gen_req count", gr_cnt, 1);

    // Reset during READY after a scored guess.
    v = '{12'h132, 0, 2'd1, 2'd2, 4'd1, 1'b0, 1'b0};
    apply("pre-rst", v);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst outputs",
        {gen_req, hits, blows, result_valid, guess_invalid, tries, win, lose, busy}, 0);
    v = '{12'h132, 2, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
    apply("idle submit", v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
